// File: rtl/pc_inst_fetch.sv
// Instruction-fetch front end: program counter driving the combinational read
// port of a word-addressed instruction ROM that also has a synchronous load port.
module pc_inst_fetch #(
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          ROM_DEPTH = 4096,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0
) (
    input  logic              i_Clk,
    input  logic              i_reset,
    input  logic              i_hold_flag,
    input  logic              i_jump_flag,
    input  logic [ADDR_W-1:0] i_jump_addr,
    input  logic              i_ce,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_w_addr,
    input  logic [DATA_W-1:0] i_w_data,
    output logic [ADDR_W-1:0] o_pc_addr,
    output logic [DATA_W-1:0] o_r_data,
    output logic [ADDR_W-1:0] o_r_addr
);

    localparam int unsigned       IDX_W   = $clog2(ROM_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] mem_q [ROM_DEPTH];
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  r_idx;

    // Byte offset and the bits above the ROM span are don't-care for the word index.
    logic [ADDR_W-IDX_W-1:0] unused_w_addr_bits;
    assign unused_w_addr_bits = {i_w_addr[ADDR_W-1:IDX_W+2], i_w_addr[1:0]};

    assign w_idx = i_w_addr[IDX_W+1:2];
    assign r_idx = pc_q[IDX_W+1:2];

    // Next PC: jump beats hold, otherwise step one word with natural wrap.
    always_comb begin
        pc_d = pc_q;
        if (i_jump_flag) begin
            pc_d = i_jump_addr;
        end else if (!i_hold_flag) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // ROM contents survive reset, so the load port ignores i_reset.
    always_ff @(posedge i_Clk) begin
        if (i_ce && i_we) begin
            mem_q[w_idx] <= i_w_data;
        end
    end

    assign o_pc_addr = pc_q;
    assign o_r_addr  = pc_q;
    assign o_r_data  = i_ce ? mem_q[r_idx] : '0;

endmodule

// File: tb/tb_pc_inst_fetch.sv
// Self-checking bench for pc_inst_fetch: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_pc_inst_fetch;

    localparam int unsigned DEPTH = 4096;

    logic        i_Clk;
    logic        i_reset;
    logic        i_hold_flag;
    logic        i_jump_flag;
    logic [31:0] i_jump_addr;
    logic        i_ce;
    logic        i_we;
    logic [31:0] i_w_addr;
    logic [31:0] i_w_data;
    logic [31:0] o_pc_addr;
    logic [31:0] o_r_data;
    logic [31:0] o_r_addr;

    int checks = 0;
    int errors = 0;

    pc_inst_fetch dut (
        .i_Clk       (i_Clk),
        .i_reset     (i_reset),
        .i_hold_flag (i_hold_flag),
        .i_jump_flag (i_jump_flag),
        .i_jump_addr (i_jump_addr),
        .i_ce        (i_ce),
        .i_we        (i_we),
        .i_w_addr    (i_w_addr),
        .i_w_data    (i_w_data),
        .o_pc_addr   (o_pc_addr),
        .o_r_data    (o_r_data),
        .o_r_addr    (o_r_addr)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Behavioural reference: PC as an unbounded integer reduced mod 2^32,
    // ROM as a sparse map from word number (byte address / 4 mod depth) to data.
    longint unsigned m_pc;
    logic [31:0]     m_mem [int];

    always @(posedge i_Clk or posedge i_reset) begin
        if (i_reset === 1'b1)
            m_pc = 0;
        else if (i_jump_flag === 1'b1)
            m_pc = longint'(i_jump_addr);
        else if (i_hold_flag !== 1'b1)
            m_pc = (m_pc + 4) % 64'h1_0000_0000;
    end

    always @(posedge i_Clk) begin
        if (i_ce === 1'b1 && i_we === 1'b1)
            m_mem[int'((longint'(i_w_addr) / 4) % DEPTH)] = i_w_data;
    end

    function automatic logic [31:0] model_read(input longint unsigned addr);
        int k;
        k = int'((addr / 4) % DEPTH);
        return m_mem.exists(k) ? m_mem[k] : 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic check_fetch(input string name, input logic [31:0] pc, input logic [31:0] data);
        check({name, " pc"}, o_pc_addr, pc);
        check({name, " r_addr"}, o_r_addr, pc);
        check({name, " r_data"}, o_r_data, data);
    endtask

    typedef struct {
        logic        hold;
        logic        jump;
        logic [31:0] jaddr;
        logic        ce;
        logic [31:0] exp_pc;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'h0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       32'h1010};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h14,       32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h18,       32'h1010};
        vecs[9]  = '{1'b1, 1'b1, 32'h2C,       1'b1, 32'h2C,       32'h1010};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h30,       32'h0};
        vecs[11] = '{1'b0, 1'b1, 32'h4,        1'b1, 32'h4,        32'h0};
        vecs[12] = '{1'b1, 1'b1, 32'h2C,       1'b1, 32'h2C,       32'h1010};
        vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h30,       32'h0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h34,       32'h0};
        vecs[15] = '{1'b0, 1'b1, 32'h10,       1'b0, 32'h10,       32'h0};
        vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       32'h1010};
        vecs[17] = '{1'b0, 1'b1, 32'h2E,       1'b1, 32'h2E,       32'h1010};
        vecs[18] = '{1'b0, 1'b1, 32'h402C,     1'b1, 32'h402C,     32'h1010};
        vecs[19] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF8, 32'h0};
        vecs[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'h0};
        vecs[21] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h0};

        i_reset     = 1'b0;
        i_hold_flag = 1'b0;
        i_jump_flag = 1'b0;
        i_jump_addr = 32'h0;
        i_ce        = 1'b1;
        i_we        = 1'b1;
        i_w_addr    = 32'h0;
        i_w_data    = 32'h0;

        // Asynchronous reset takes effect before any clock edge.
        #1 i_reset = 1'b1;
        #1 check("reset async pc", o_pc_addr, 32'h0);

        // Load the whole ROM through the write port while reset is held;
        // 0x1010 lands at byte addresses 0x10, 0x18 and 0x2C.
        for (int i = 0; i < int'(DEPTH); i++) begin
            i_w_addr = 32'(i * 4);
            i_w_data = (i == 4 || i == 6 || i == 11) ? 32'h1010 : 32'h0;
            step();
        end
        i_we = 1'b0;
        check_fetch("reset held", 32'h0, 32'h0);

        i_reset = 1'b0;
        check_fetch("reset release", 32'h0, 32'h0);

        for (int v = 0; v < NVEC; v++) begin
            i_hold_flag = vecs[v].hold;
            i_jump_flag = vecs[v].jump;
            i_jump_addr = vecs[v].jaddr;
            i_ce        = vecs[v].ce;
            step();
            check_fetch($sformatf("vec%0d", v), vecs[v].exp_pc, vecs[v].exp_data);
        end
        i_hold_flag = 1'b0;
        i_jump_flag = 1'b0;
        i_ce        = 1'b1;

        // Reset pulse between edges at PC 0x40; ROM must survive it.
        i_jump_flag = 1'b1;
        i_jump_addr = 32'h40;
        step();
        i_jump_flag = 1'b0;
        check("midrun pre pc", o_pc_addr, 32'h40);
        #2 i_reset = 1'b1;
        #1 check_fetch("midrun reset", 32'h0, 32'h0);
        #1 i_reset = 1'b0;
        step();
        check_fetch("midrun resume", 32'h4, 32'h0);
        i_jump_flag = 1'b1;
        i_jump_addr = 32'h10;
        step();
        i_jump_flag = 1'b0;
        check_fetch("midrun rom kept", 32'h10, 32'h1010);

        // Write attempted with ce low must be dropped.
        i_ce        = 1'b0;
        i_we        = 1'b1;
        i_w_addr    = 32'h20;
        i_w_data    = 32'hDEAD;
        i_jump_flag = 1'b1;
        i_jump_addr = 32'h20;
        step();
        check_fetch("ce0 write", 32'h20, 32'h0);
        i_jump_flag = 1'b0;
        i_hold_flag = 1'b1;
        i_we        = 1'b0;
        i_ce        = 1'b1;
        #1 check("ce1 comb read", o_r_data, 32'h0);
        step();
        check_fetch("ce0 write dropped", 32'h20, 32'h0);

        // Read-during-write: old word until the edge, new word after it.
        i_we     = 1'b1;
        i_w_data = 32'hBEEF;
        #1 check("rdw before edge", o_r_data, 32'h0);
        step();
        i_we = 1'b0;
        check_fetch("rdw after edge", 32'h20, 32'hBEEF);
        i_hold_flag = 1'b0;

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            i_hold_flag = ($urandom_range(0, 3) == 0);
            i_jump_flag = ($urandom_range(0, 6) == 0);
            case ($urandom_range(0, 9))
                0:       i_jump_addr = $urandom;
                1:       i_jump_addr = 32'($urandom_range(0, 63) * 4) | 32'h0000_4000;
                2:       i_jump_addr = 32'($urandom_range(0, 255));
                default: i_jump_addr = 32'($urandom_range(0, 63) * 4);
            endcase
            i_ce     = ($urandom_range(0, 9) != 0);
            i_we     = ($urandom_range(0, 2) == 0);
            i_w_addr = 32'($urandom_range(0, 63) * 4) |
                       (($urandom_range(0, 4) == 0) ? 32'hABC0_C003 & 32'hFFFF_C003 : 32'h0);
            i_w_data = $urandom;
            if ($urandom_range(0, 49) == 0) begin
                #2 i_reset = 1'b1;
                #1 check("rand async reset pc", o_pc_addr, 32'(m_pc));
                i_reset = 1'b0;
            end
            step();
            check_fetch($sformatf("rand%0d", n), 32'(m_pc),
                        i_ce ? model_read(m_pc) : 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
